// File: rtl/alu_pkg.sv
// Op codes, op-class helpers and FSM states shared by seq_alu and its
// iterative multiply/divide engine.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLL    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_SLT    = 5'd8,
      OP_SLTU   = 5'd9,
      OP_MUL    = 5'd16,
      OP_MULH   = 5'd17,
      OP_MULHSU = 5'd18,
      OP_MULHU  = 5'd19,
      OP_DIV    = 5'd20,
      OP_DIVU   = 5'd21,
      OP_REM    = 5'd22,
      OP_REMU   = 5'd23
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   function automatic logic is_iter(input logic [4:0] op);
      return op[4:3] == 2'b10;
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_signed_a(input logic [4:0] op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(input logic [4:0] op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Shared iterative engine: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, followed by a FIX cycle for sign correction and selection.
module seq_muldiv_core
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter bit DIV_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            fin,
   output logic [XLEN-1:0] res
);

   localparam int CW = $clog2(XLEN);

   state_e            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opd;
   alu_op_e           op_q;
   logic              neg_q, neg_r;

   logic              neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     msum, rem_s, diff;
   logic [2*XLEN-1:0] mul_step, div_step, prod;
   logic [XLEN-1:0]   quot, remd;

   assign neg_a = is_signed_a(op) & a[XLEN-1];
   assign neg_b = is_signed_b(op) & b[XLEN-1];
   assign mag_a = neg_a ? -a : a;
   assign mag_b = neg_b ? -b : b;

   // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right.
   assign msum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
   assign mul_step = {msum, acc[XLEN-1:1]};

   // Divide: acc = {remainder, quotient}; shift left, keep trial when no borrow.
   assign rem_s    = acc[2*XLEN-1:XLEN-1];
   assign diff     = rem_s - {1'b0, opd};
   assign div_step = diff[XLEN] ? {rem_s[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            if (flush)                      state_nxt = ST_IDLE;
            else if (cnt == CW'(XLEN - 1))  state_nxt = ST_FIX;
         end
         ST_FIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         acc   <= '0;
         opd   <= '0;
         op_q  <= OP_ADD;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == ST_IDLE && start) begin
         cnt   <= '0;
         acc   <= is_div(op) ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
         opd   <= is_div(op) ? mag_b : mag_a;
         op_q  <= alu_op_e'(op);
         neg_q <= neg_a ^ neg_b;
         neg_r <= neg_a;
      end else if (state == ST_RUN) begin
         cnt <= cnt + 1'b1;
         acc <= (DIV_EN && is_div(op_q)) ? div_step : mul_step;
      end
   end

   assign prod = neg_q ? -acc : acc;
   assign quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
   assign remd = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

   always_comb begin
      res = '0;
      case (op_q)
         OP_MUL:                       res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              res = quot;
         OP_REM, OP_REMU:              res = remd;
         default:                      res = '0;
      endcase
   end

   assign busy = (state != ST_IDLE);
   assign fin  = (state == ST_FIX);

endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle base ops and division short-cuts in place,
// multiply/divide handed to the iterative core; result and flags registered.
module seq_alu
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter bit DIV_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            eq,
   output logic            lt,
   output logic            ltu
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0]  shamt;
   logic            cmp_eq, cmp_lt, cmp_ltu;
   logic            div_zero, div_ovf;
   logic            accept, iter_go, simple_go;
   logic [XLEN-1:0] simple_res, core_res;
   logic            core_fin;
   logic            pend_eq, pend_lt, pend_ltu;

   assign shamt    = b[SHW-1:0];
   assign cmp_eq   = (a == b);
   assign cmp_lt   = ($signed(a) < $signed(b));
   assign cmp_ltu  = (a < b);
   assign div_zero = (b == '0);
   assign div_ovf  = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

   // Division corner cases never enter the engine; they finish in one cycle.
   assign accept    = start && !busy;
   assign iter_go   = accept && is_iter(op) &&
                      !(is_div(op) && (!DIV_EN || div_zero || (is_signed_a(op) && div_ovf)));
   assign simple_go = accept && !iter_go;

   always_comb begin
      simple_res = '0;
      case (op)
         OP_ADD:          simple_res = a + b;
         OP_SUB:          simple_res = a - b;
         OP_AND:          simple_res = a & b;
         OP_OR:           simple_res = a | b;
         OP_XOR:          simple_res = a ^ b;
         OP_SLL:          simple_res = a << shamt;
         OP_SRL:          simple_res = a >> shamt;
         OP_SRA:          simple_res = XLEN'($signed(a) >>> shamt);
         OP_SLT:          simple_res = {{(XLEN-1){1'b0}}, cmp_lt};
         OP_SLTU:         simple_res = {{(XLEN-1){1'b0}}, cmp_ltu};
         OP_DIV, OP_DIVU: simple_res = (!DIV_EN || div_zero) ? '1 : a;
         OP_REM, OP_REMU: simple_res = !DIV_EN ? '1 : (div_zero ? a : '0);
         default:         simple_res = '0;
      endcase
   end

   seq_muldiv_core #(
      .XLEN   (XLEN),
      .DIV_EN (DIV_EN)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .start (iter_go),
      .flush (flush),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .fin   (core_fin),
      .res   (core_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done     <= 1'b0;
         result   <= '0;
         eq       <= 1'b0;
         lt       <= 1'b0;
         ltu      <= 1'b0;
         pend_eq  <= 1'b0;
         pend_lt  <= 1'b0;
         pend_ltu <= 1'b0;
      end else begin
         done <= 1'b0;
         if (simple_go) begin
            done   <= 1'b1;
            result <= simple_res;
            eq     <= cmp_eq;
            lt     <= cmp_lt;
            ltu    <= cmp_ltu;
         end else if (core_fin && !flush) begin
            done   <= 1'b1;
            result <= core_res;
            eq     <= pend_eq;
            lt     <= pend_lt;
            ltu    <= pend_ltu;
         end
         // Flags come from the operands seen at start, not from later bus values.
         if (iter_go) begin
            pend_eq  <= cmp_eq;
            pend_lt  <= cmp_lt;
            pend_ltu <= cmp_ltu;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed vectors push expectations, a monitor
// checks result, flags and completion cycle on every done pulse.
module tb_seq_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [4:0]  op;
   logic [31:0] a, b, result;
   logic        busy, done, eq, lt, ltu;

   seq_alu #(.XLEN(32), .DIV_EN(1'b1)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .flush  (flush),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .eq     (eq),
      .lt     (lt),
      .ltu    (ltu)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       nm;
      logic [31:0] res;
      logic [2:0]  fl;
      int          edge_n;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   n_cmp = 0;
   int   errs  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            errs++;
            $display("FAIL unexpected_done: got done with result %h at cycle %0d, want no done", result, cyc);
         end else begin
            m_e = sb.pop_front();
            chk({m_e.nm, "_res"},   result, m_e.res);
            chk({m_e.nm, "_flags"}, {29'b0, eq, lt, ltu}, {29'b0, m_e.fl});
            chk({m_e.nm, "_cycle"}, cyc, m_e.edge_n);
         end
      end
   end

   task automatic issue(input string nm, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      e.nm     = nm;
      e.res    = exp;
      e.fl     = {x == y, $signed(x) < $signed(y), x < y};
      e.edge_n = cyc + lat;
      sb.push_back(e);
   endtask

   // Operand buses are scrambled while waiting to prove operands are captured.
   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         start = 1'b0;
         flush = 1'b0;
         a     = $urandom;
         b     = $urandom;
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         errs++;
         $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_done",   32'(done), 32'd0);
      chk("rst_result", result,    32'd0);
      chk("rst_flags",  {29'b0, eq, lt, ltu}, 32'd0);
      rst = 1'b0;

      // Back-to-back single-cycle ops
      issue("add_wrap", OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1);
      issue("sra",      OP_SRA,  32'h8000_0000, 32'h24,        32'hF800_0000, 1);
      issue("sub",      OP_SUB,  32'h5,         32'h7,         32'hFFFF_FFFE, 1);
      issue("xor",      OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
      issue("and",      OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
      issue("or",       OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1);
      issue("sll",      OP_SLL,  32'h1,         32'h3F,        32'h8000_0000, 1);
      issue("srl",      OP_SRL,  32'h8000_0000, 32'h4,         32'h0800_0000, 1);
      issue("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1);
      issue("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1);
      issue("unknown",  5'd12,   32'h5,         32'h5,         32'h0,         1);
      drain();

      // Iterative multiply
      issue("mulhu_max", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34); drain();
      issue("mul_neg",   OP_MUL,    32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB, 34); drain();
      issue("mulh_neg",  OP_MULH,   32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 34); drain();
      issue("mulh_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34); drain();
      issue("mulhsu",    OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34); drain();
      issue("mulhu_sm",  OP_MULHU,  32'h8000_0000, 32'h2,         32'h1,         34); drain();

      // Iterative divide
      issue("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34); drain();
      issue("rem_neg",   OP_REM,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34); drain();
      issue("divu",      OP_DIVU, 32'd100,       32'd7,         32'd14,        34); drain();
      issue("remu",      OP_REMU, 32'd100,       32'd7,         32'd2,         34); drain();
      issue("div_negb",  OP_DIV,  32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34); drain();
      issue("rem_negb",  OP_REM,  32'h7,         32'hFFFF_FFFE, 32'h1,         34); drain();
      issue("divu_max",  OP_DIVU, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 34); drain();

      // Division short-cuts
      issue("div_zero",  OP_DIV,  32'h55,        32'h0,         32'hFFFF_FFFF, 1);
      issue("rem_zero",  OP_REM,  32'h1234,      32'h0,         32'h1234,      1);
      issue("divu_zero", OP_DIVU, 32'h9,         32'h0,         32'hFFFF_FFFF, 1);
      issue("remu_zero", OP_REMU, 32'h9,         32'h0,         32'h9,         1);
      issue("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      issue("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
      drain();

      // Start with flush while idle is still accepted
      issue("add_flush_idle", OP_ADD, 32'h10, 32'h20, 32'h30, 1);
      flush = 1'b1;
      drain();

      // Ignored start while busy, then flush: no done for either
      @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         start = 1'b0;
         flush = 1'b0;
         if (k == 5) begin
            start = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h2;
         end
         if (k == 10) begin
            chk("flush_busy_before", 32'(busy), 32'd1);
            flush = 1'b1;
         end
         if (k == 11) chk("flush_busy_after", 32'(busy), 32'd0);
      end
      repeat (40) @(negedge clk);
      issue("add_after_flush", OP_ADD, 32'h1, 32'h2, 32'h3, 1);
      drain();

      // Asynchronous reset in the middle of a multiply
      @(negedge clk);
      start = 1'b1; op = OP_MUL; a = 32'hFFFF_FFFD; b = 32'h7;
      repeat (10) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("mid_mul_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy",   32'(busy), 32'd0);
      chk("arst_done",   32'(done), 32'd0);
      chk("arst_result", result,    32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);

      issue("add_after_rst", OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
      drain();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, errs);
      $finish;
   end

endmodule
